// File: rtl/spi_burst_pkg.sv
// Shared types and width helpers for the SSD1306 serial shift engine.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LEAD,
    TRAIL,
    HOLD,
    GAP
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 2;

  function automatic int cnt_width(input int div);
    return $clog2(div + 1);
  endfunction

  function automatic int idx_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_timer.sv
// SCLK half-period down-counter: reload to DIV-1, expire strobe at terminal count zero.
module spi_sclk_timer #(
  parameter int DIV = 2,
  parameter int CW  = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  output logic expire_o
);

  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_burst_shifter.sv
// Serial shift engine for the SSD1306 bus: one-word holding buffer, divided SCLK, CS#-held bursts.
// state | meaning
// IDLE  | CS# high, waiting for a buffered word
// SETUP | first bit on MOSI, SCLK idle for DIV cycles
// LEAD  | SCLK active, MISO sampled on entry
// TRAIL | SCLK idle, next bit shifted out on entry; word-done decision at expiry
// HOLD  | word done, CS# held low, buffer starved
// GAP   | CS# high guard interval before IDLE
module spi_burst_shifter
  import spi_burst_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter int MSB_FIRST = 1,
  parameter int CPOL      = 0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             tx_valid_in,
  output logic             tx_ready_out,
  input  logic [WIDTH-1:0] tx_data_in,
  input  logic             tx_dc_in,
  input  logic             tx_last_in,
  output logic             rx_valid_out,
  output logic [WIDTH-1:0] rx_data_out,
  output logic             busy_out,
  output logic             sclk_out,
  output logic             mosi_out,
  input  logic             miso_in,
  output logic             cs_n_out,
  output logic             dc_out
);

  localparam int              CW        = cnt_width(DIV);
  localparam int              IW        = idx_width(WIDTH);
  localparam logic            SCLK_IDLE = (CPOL != 0);
  localparam logic [IW-1:0]   BITS_DONE = IW'(WIDTH);
  localparam logic [IW-1:0]   BIT_ONE   = IW'(1);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  state_t           state_q, state_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;
  logic             buf_dc_q, buf_dc_d;
  logic             buf_last_q, buf_last_d;
  logic             ready_q;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [IW-1:0]    bits_q, bits_d;
  logic             last_q, last_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             dc_q, dc_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             busy_q;

  logic tmr_load, tmr_expire;
  logic push, pop, load_word, sample, shift;

  spi_sclk_timer #(.DIV(DIV), .CW(CW)) u_timer (
    .clk_i   (clk_in),
    .rst_n_i (reset_in),
    .load_i  (tmr_load),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bits_d     = bits_q;
    last_d     = last_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    dc_d       = dc_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tmr_load   = 1'b0;
    load_word  = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE:  if (buf_full_q) load_word = 1'b1;
      SETUP: if (tmr_expire) begin
        state_d = LEAD;
        sample  = 1'b1;
      end
      LEAD: if (tmr_expire) begin
        state_d  = TRAIL;
        tmr_load = 1'b1;
        shift    = (bits_q != BITS_DONE);
      end
      TRAIL: if (tmr_expire) begin
        if (bits_q != BITS_DONE) begin
          state_d = LEAD;
          sample  = 1'b1;
        end else begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sr_q;
          if (last_q) begin
            state_d  = GAP;
            cs_n_d   = 1'b1;
            tmr_load = 1'b1;
          end else if (buf_full_q) begin
            load_word = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD:    if (buf_full_q) load_word = 1'b1;
      GAP:     if (tmr_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sample) begin
      tmr_load = 1'b1;
      bits_d   = bits_q + BIT_ONE;
      rx_sr_d  = shift_in(rx_sr_q, miso_in);
    end
    if (shift) begin
      tx_sr_d = shift_out(tx_sr_q);
      mosi_d  = first_bit(tx_sr_d);
    end
    if (load_word) begin
      state_d  = SETUP;
      tmr_load = 1'b1;
      pop      = 1'b1;
      tx_sr_d  = buf_data_q;
      mosi_d   = first_bit(buf_data_q);
      dc_d     = buf_dc_q;
      last_d   = buf_last_q;
      cs_n_d   = 1'b0;
      bits_d   = '0;
    end

    // SCLK is a registered decode of the next state, so it is active exactly while in LEAD.
    sclk_d = (state_d == LEAD) ? ~SCLK_IDLE : SCLK_IDLE;

    push       = tx_valid_in & ready_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_dc_d   = buf_dc_q;
    buf_last_d = buf_last_q;
    if (pop) buf_full_d = 1'b0;
    if (push) begin
      buf_full_d = 1'b1;
      buf_data_d = tx_data_in;
      buf_dc_d   = tx_dc_in;
      buf_last_d = tx_last_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_dc_q   <= 1'b0;
      buf_last_q <= 1'b0;
      ready_q    <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bits_q     <= '0;
      last_q     <= 1'b0;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_dc_q   <= buf_dc_d;
      buf_last_q <= buf_last_d;
      ready_q    <= ~buf_full_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bits_q     <= bits_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      dc_q       <= dc_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign tx_ready_out = ready_q;
  assign rx_valid_out = rx_valid_q;
  assign rx_data_out  = rx_data_q;
  assign busy_out     = busy_q;
  assign sclk_out     = sclk_q;
  assign mosi_out     = mosi_q;
  assign cs_n_out     = cs_n_q;
  assign dc_out       = dc_q;

endmodule

// File: tb/tb_spi_burst_shifter.sv
// Directed bench: MSB-first/CPOL=0 and LSB-first/CPOL=1 engines, both with MISO looped to MOSI.
module tb_spi_burst_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       rst_n;
  logic       v0, rdy0, dc0, last0, rxv0, busy0, sclk0, mosi0, miso0, cs0, dco0;
  logic [7:0] d0, rxd0;
  logic       v1, rdy1, dc1, last1, rxv1, busy1, sclk1, mosi1, miso1, cs1, dco1;
  logic [7:0] d1, rxd1;

  assign miso0 = mosi0;
  assign miso1 = mosi1;

  spi_burst_shifter #(.WIDTH(8), .DIV(2), .MSB_FIRST(1), .CPOL(0)) dut0 (
    .clk_in(clk), .reset_in(rst_n), .tx_valid_in(v0), .tx_ready_out(rdy0),
    .tx_data_in(d0), .tx_dc_in(dc0), .tx_last_in(last0), .rx_valid_out(rxv0),
    .rx_data_out(rxd0), .busy_out(busy0), .sclk_out(sclk0), .mosi_out(mosi0),
    .miso_in(miso0), .cs_n_out(cs0), .dc_out(dco0)
  );

  spi_burst_shifter #(.WIDTH(8), .DIV(2), .MSB_FIRST(0), .CPOL(1)) dut1 (
    .clk_in(clk), .reset_in(rst_n), .tx_valid_in(v1), .tx_ready_out(rdy1),
    .tx_data_in(d1), .tx_dc_in(dc1), .tx_last_in(last1), .rx_valid_out(rxv1),
    .rx_data_out(rxd1), .busy_out(busy1), .sclk_out(sclk1), .mosi_out(mosi1),
    .miso_in(miso1), .cs_n_out(cs1), .dc_out(dco1)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observers: only these blocks write the recorded history.
  int         lead_t0[$];
  logic       bits0[$];
  logic       dcq0[$];
  logic [7:0] rxq0[$];
  int         cs_len0 = 0, last_cs_len0 = 0, cs_rise0 = 0;
  int         hold_bad0 = 0, width_bad0 = 0, idle_bad0 = 0, act_w0 = 0;

  initial begin
    logic ps, pm, pd, pc;
    ps = 1'b0; pm = 1'b0; pd = 1'b0; pc = 1'b1;
    forever begin
      @(negedge clk);
      if (sclk0 === 1'b1 && ps === 1'b0) begin
        lead_t0.push_back(cyc);
        bits0.push_back(mosi0);
        dcq0.push_back(dco0);
      end
      if (sclk0 === 1'b1 && ps === 1'b1 && (mosi0 !== pm || dco0 !== pd)) hold_bad0++;
      if (sclk0 === 1'b1 && cs0 === 1'b1) idle_bad0++;
      if (sclk0 === 1'b1) act_w0++;
      else if (ps === 1'b1) begin
        if (act_w0 != 2) width_bad0++;
        act_w0 = 0;
      end
      if (cs0 === 1'b0) cs_len0++;
      else if (pc === 1'b0) begin
        last_cs_len0 = cs_len0;
        cs_rise0++;
        cs_len0 = 0;
      end
      if (rxv0 === 1'b1) rxq0.push_back(rxd0);
      ps = sclk0; pm = mosi0; pd = dco0; pc = cs0;
    end
  end

  int         lead_t1[$];
  logic       bits1[$];
  logic [7:0] rxq1[$];
  int         idle_bad1 = 0;

  initial begin
    logic ps;
    ps = 1'b1;
    forever begin
      @(negedge clk);
      if (sclk1 === 1'b0 && ps === 1'b1) begin
        lead_t1.push_back(cyc);
        bits1.push_back(mosi1);
      end
      if (sclk1 === 1'b0 && cs1 === 1'b1) idle_bad1++;
      if (rxv1 === 1'b1) rxq1.push_back(rxd1);
      ps = sclk1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d, input logic dc, input logic last, output int t);
    int n;
    n = 0;
    d0 = d; dc0 = dc; last0 = last;
    while (rdy0 !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) timeout("push0");
    v0 = 1'b1;
    tick();
    t  = cyc;
    v0 = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    d1 = d; dc1 = 1'b0; last1 = last;
    while (rdy1 !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) timeout("push1");
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while ((busy0 !== 1'b0 || rdy0 !== 1'b1) && n < 600) begin tick(); n++; end
    if (n >= 600) timeout("idle0");
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while ((busy1 !== 1'b0 || rdy1 !== 1'b1) && n < 600) begin tick(); n++; end
    if (n >= 600) timeout("idle1");
  endtask

  task automatic wait_leads0(input int target);
    int n;
    n = 0;
    while (lead_t0.size() < target && n < 600) begin tick(); n++; end
    if (n >= 600) timeout("leads0");
  endtask

  task automatic wait_rx0(input int target);
    int n;
    n = 0;
    while (rxq0.size() < target && n < 600) begin tick(); n++; end
    if (n >= 600) timeout("rx0");
  endtask

  function automatic logic [7:0] msb_word0(input int base);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w = {w[6:0], bits0[base+k]};
    return w;
  endfunction

  function automatic logic [7:0] lsb_word1(input int base);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k] = bits1[base+k];
    return w;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_rx;
    logic       exp_first;
  } vec_t;

  vec_t tv0[6];
  vec_t tv1[3];

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int lb, rb, cb, t;
    logic [7:0] bp[5];

    tv0[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1};
    tv0[1] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    tv0[2] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    tv0[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tv0[4] = '{8'h80, 1'b0, 8'h80, 1'b1};
    tv0[5] = '{8'h01, 1'b1, 8'h01, 1'b0};
    tv1[0] = '{8'h01, 1'b0, 8'h01, 1'b1};
    tv1[1] = '{8'h80, 1'b0, 8'h80, 1'b0};
    tv1[2] = '{8'hC3, 1'b0, 8'hC3, 1'b1};

    rst_n = 1'b0;
    v0 = 1'b0; d0 = '0; dc0 = 1'b0; last0 = 1'b0;
    v1 = 1'b0; d1 = '0; dc1 = 1'b0; last1 = 1'b0;
    repeat (3) tick();
    check("rst_sclk0", sclk0, 1'b0);
    check("rst_cs0", cs0, 1'b1);
    check("rst_mosi0", mosi0, 1'b0);
    check("rst_dc0", dco0, 1'b0);
    check("rst_ready0", rdy0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_rxv0", rxv0, 1'b0);
    check("rst_rxd0", rxd0, 8'h00);
    check("rst_sclk1", sclk1, 1'b1);
    check("rst_cs1", cs1, 1'b1);
    rst_n = 1'b1;
    repeat (2) tick();
    check("ready_after_rst", rdy0, 1'b1);

    // Single last words through the MSB-first engine.
    for (int i = 0; i < 6; i++) begin
      lb = lead_t0.size(); rb = rxq0.size();
      push0(tv0[i].data, tv0[i].dc, 1'b1, t);
      if (i == 0) begin
        check("cs_before_load", cs0, 1'b1);
        check("ready_full", rdy0, 1'b0);
        tick();
        check("cs_latency", cs0, 1'b0);
        check("busy_latency", busy0, 1'b1);
        check("mosi_first", mosi0, tv0[i].exp_first);
      end
      wait_idle0();
      check("lead_count", lead_t0.size() - lb, 8);
      check("mosi_bits", msb_word0(lb), tv0[i].data);
      check("rx_count", rxq0.size() - rb, 1);
      check("rx_data", rxq0[rb], tv0[i].exp_rx);
      check("cs_low_len", last_cs_len0, 34);
      check("dc_word", dcq0[lb], tv0[i].dc);
      check("first_lead_delay", lead_t0[lb] - t, 3);
      check("sclk_period", lead_t0[lb+1] - lead_t0[lb], 4);
    end
    check("sclk_width", width_bad0, 0);

    // LSB-first, CPOL=1 engine.
    for (int i = 0; i < 3; i++) begin
      lb = lead_t1.size(); rb = rxq1.size();
      check("sclk1_idle", sclk1, 1'b1);
      push1(tv1[i].data, 1'b1);
      wait_idle1();
      check("lead_count1", lead_t1.size() - lb, 8);
      check("first_bit1", bits1[lb], tv1[i].exp_first);
      check("mosi_bits1", lsb_word1(lb), tv1[i].data);
      check("rx_data1", rxq1[rb], tv1[i].exp_rx);
    end
    check("sclk1_idle_end", sclk1, 1'b1);
    check("sclk1_idle_cs_high", idle_bad1, 0);

    // Burst of three, CS# held low.
    lb = lead_t0.size(); rb = rxq0.size(); cb = cs_rise0;
    push0(8'h11, 1'b0, 1'b0, t);
    push0(8'h22, 1'b1, 1'b0, t);
    push0(8'h33, 1'b1, 1'b1, t);
    wait_idle0();
    check("burst_cs_rises", cs_rise0 - cb, 1);
    check("burst_leads", lead_t0.size() - lb, 24);
    check("burst_rx_count", rxq0.size() - rb, 3);
    check("burst_rx0", rxq0[rb], 8'h11);
    check("burst_rx1", rxq0[rb+1], 8'h22);
    check("burst_rx2", rxq0[rb+2], 8'h33);
    check("burst_dc0", dcq0[lb], 1'b0);
    check("burst_dc1", dcq0[lb+8], 1'b1);
    check("burst_dc2", dcq0[lb+16], 1'b1);
    check("burst_gap01", lead_t0[lb+8] - lead_t0[lb+7], 6);
    check("burst_gap12", lead_t0[lb+16] - lead_t0[lb+15], 6);
    check("burst_bits2", msb_word0(lb + 16), 8'h33);
    check("burst_cs_len", last_cs_len0, 3 * 34);

    // Starvation: second word arrives well after the first finishes.
    lb = lead_t0.size(); rb = rxq0.size(); cb = cs_rise0;
    push0(8'h5A, 1'b0, 1'b0, t);
    wait_rx0(rb + 1);
    repeat (10) tick();
    check("hold_busy", busy0, 1'b1);
    check("hold_cs", cs0, 1'b0);
    check("hold_sclk", sclk0, 1'b0);
    check("hold_ready", rdy0, 1'b1);
    push0(8'hC3, 1'b1, 1'b1, t);
    wait_idle0();
    check("resume_delay", lead_t0[lb+8] - t, 3);
    check("starve_rx0", rxq0[rb], 8'h5A);
    check("starve_rx1", rxq0[rb+1], 8'hC3);
    check("starve_cs_rises", cs_rise0 - cb, 1);
    check("starve_dc", dcq0[lb+8], 1'b1);

    // Back-pressure: valid held while the buffer is full.
    bp[0] = 8'h10; bp[1] = 8'h21; bp[2] = 8'h32; bp[3] = 8'h43; bp[4] = 8'h54;
    rb = rxq0.size(); cb = cs_rise0;
    push0(bp[0], 1'b0, 1'b0, t);
    push0(bp[1], 1'b0, 1'b0, t);
    d0 = bp[2]; v0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_ready_low", rdy0, 1'b0);
    end
    for (int k = 2; k < 5; k++) push0(bp[k], 1'b0, (k == 4), t);
    wait_idle0();
    check("bp_rx_count", rxq0.size() - rb, 5);
    for (int k = 0; k < 5; k++) check("bp_rx", rxq0[rb+k], bp[k]);
    check("bp_cs_rises", cs_rise0 - cb, 1);

    // Reset while bit 4 of 0xF0 is on the wire.
    lb = lead_t0.size(); rb = rxq0.size();
    push0(8'hF0, 1'b0, 1'b1, t);
    wait_leads0(lb + 5);
    rst_n = 1'b0;
    tick();
    check("rst_mid_cs", cs0, 1'b1);
    check("rst_mid_sclk", sclk0, 1'b0);
    check("rst_mid_ready", rdy0, 1'b0);
    check("rst_mid_busy", busy0, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("rst_mid_no_rx", rxq0.size() - rb, 0);
    check("rst_mid_ready_back", rdy0, 1'b1);
    lb = lead_t0.size();
    push0(8'h3C, 1'b1, 1'b1, t);
    wait_idle0();
    check("post_rst_rx_count", rxq0.size() - rb, 1);
    check("post_rst_rx", rxq0[rb], 8'h3C);
    check("post_rst_bits", msb_word0(lb), 8'h3C);
    check("post_rst_cs_len", last_cs_len0, 34);

    check("mosi_dc_stable", hold_bad0, 0);
    check("sclk0_idle_cs_high", idle_bad0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
